// File: rtl/sha256_ctrl_pkg.sv
// Shared types and defaults for the SHA-256 block controller.
// Holds the FSM state enum, default sizes and a small max helper.
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HASH_INIT,
        ST_LOAD,
        ST_COMP_SET,
        ST_COMPRESS,
        ST_HASH_SUM
    } sha_ctrl_state_t;

    localparam int SHA_ROUNDS     = 64;
    localparam int SHA_LOAD_WORDS = 16;
    localparam int SHA_SUM_CYCLES = 1;
    localparam int SHA_BLK_W      = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sha256_step_counter.sv
// Clearable up-counter that wraps to zero after reaching TERM.
// Ports: CLK, RESET_N, clear, enable; wrap (enable at TERM), count.
module sha256_step_counter #(
    parameter int W    = 6,
    parameter int TERM = 15
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         clear,
    input  logic         enable,
    output logic         wrap,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    assign wrap = enable && (count == TERM_V);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block sequencer for the SHA-256 datapath: IV init, message load,
// compression rounds and hash sum, with chaining, stall and abort.
// Inputs: CLK, RESET_N, START, FIRST_BLOCK, LAST_BLOCK, MSG_VALID, ABORT.
// Outputs: SET_HASH, LOAD_EN/LOAD_IDX, SET_COMPRESSION, COMPRESSION_EN,
// ROUND_IDX, LD_HASH, BUSY, BLOCK_DONE, DONE, BLOCK_CNT.
module sha256_block_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int ROUNDS     = SHA_ROUNDS,
    parameter int LOAD_WORDS = SHA_LOAD_WORDS,
    parameter int SUM_CYCLES = SHA_SUM_CYCLES,
    parameter int BLK_W      = SHA_BLK_W,
    localparam int IDX_W     = $clog2(max2(ROUNDS, LOAD_WORDS))
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             FIRST_BLOCK,
    input  logic             LAST_BLOCK,
    input  logic             MSG_VALID,
    input  logic             ABORT,
    output logic             SET_HASH,
    output logic             LOAD_EN,
    output logic [IDX_W-1:0] LOAD_IDX,
    output logic             SET_COMPRESSION,
    output logic             COMPRESSION_EN,
    output logic [IDX_W-1:0] ROUND_IDX,
    output logic             LD_HASH,
    output logic             BUSY,
    output logic             BLOCK_DONE,
    output logic             DONE,
    output logic [BLK_W-1:0] BLOCK_CNT
);

    localparam int SUM_W = (SUM_CYCLES > 1) ? $clog2(SUM_CYCLES) : 1;
    localparam logic [SUM_W-1:0] SUM_LAST = SUM_W'(SUM_CYCLES - 1);

    sha_ctrl_state_t  state_q, state_d;
    logic             last_q;
    logic [SUM_W-1:0] sum_cnt;
    logic             blk_done_q;
    logic             done_q;
    logic [BLK_W-1:0] blk_cnt_q;

    logic             ld_wrap, rnd_wrap;
    logic [IDX_W-1:0] ld_cnt, rnd_cnt;
    logic             cnt_clear;
    logic             accept;
    logic             sum_last;
    logic             block_end;

    assign cnt_clear = ABORT || (state_q == ST_IDLE);
    assign accept    = (state_q == ST_IDLE) && START && !ABORT;
    assign sum_last  = (state_q == ST_HASH_SUM) && (sum_cnt == SUM_LAST);
    // An abort on the last sum cycle suppresses completion.
    assign block_end = sum_last && !ABORT;

    sha256_step_counter #(
        .W    (IDX_W),
        .TERM (LOAD_WORDS - 1)
    ) u_load_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clear   (cnt_clear),
        .enable  (LOAD_EN),
        .wrap    (ld_wrap),
        .count   (ld_cnt)
    );

    sha256_step_counter #(
        .W    (IDX_W),
        .TERM (ROUNDS - 1)
    ) u_round_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clear   (cnt_clear),
        .enable  (COMPRESSION_EN),
        .wrap    (rnd_wrap),
        .count   (rnd_cnt)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        SET_HASH        = 1'b0;
        LOAD_EN         = 1'b0;
        SET_COMPRESSION = 1'b0;
        COMPRESSION_EN  = 1'b0;
        LD_HASH         = 1'b0;
        BUSY            = (state_q != ST_IDLE);
        LOAD_IDX        = ld_cnt;
        ROUND_IDX       = rnd_cnt;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = FIRST_BLOCK ? ST_HASH_INIT : ST_LOAD;
                end
            end
            ST_HASH_INIT: begin
                SET_HASH = 1'b1;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                LOAD_EN = MSG_VALID;
                if (ld_wrap) begin
                    state_d = ST_COMP_SET;
                end
            end
            ST_COMP_SET: begin
                SET_COMPRESSION = 1'b1;
                state_d         = ST_COMPRESS;
            end
            ST_COMPRESS: begin
                COMPRESSION_EN = 1'b1;
                if (rnd_wrap) begin
                    state_d = ST_HASH_SUM;
                end
            end
            ST_HASH_SUM: begin
                LD_HASH = (sum_cnt == '0);
                if (sum_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ABORT) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q     <= 1'b0;
            sum_cnt    <= '0;
            blk_done_q <= 1'b0;
            done_q     <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            if (accept) begin
                last_q <= LAST_BLOCK;
            end

            if (state_q != ST_HASH_SUM || ABORT || sum_last) begin
                sum_cnt <= '0;
            end else begin
                sum_cnt <= sum_cnt + 1'b1;
            end

            blk_done_q <= block_end;

            if (accept) begin
                done_q <= 1'b0;
            end else if (block_end && last_q) begin
                done_q <= 1'b1;
            end

            if (state_q == ST_HASH_INIT && !ABORT) begin
                blk_cnt_q <= '0;
            end else if (block_end) begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

    assign BLOCK_DONE = blk_done_q;
    assign DONE       = done_q;
    assign BLOCK_CNT  = blk_cnt_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl: default-size instance plus
// a ROUNDS=80 / LOAD_WORDS=64 / SUM_CYCLES=4 instance.
module tb_sha256_block_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic first = 1'b0;
    logic last = 1'b0;
    logic msg = 1'b1;
    logic abort = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic        sh1, le1, sc1, ce1, lh1, by1, bd1, dn1;
    logic [5:0]  li1, ri1;
    logic [15:0] bc1;
    logic        sh2, le2, sc2, ce2, lh2, by2, bd2, dn2;
    logic [6:0]  li2, ri2;
    logic [15:0] bc2;

    logic st1, st2, ab1, ab2;
    assign st1 = start && !sel;
    assign st2 = start && sel;
    assign ab1 = abort && !sel;
    assign ab2 = abort && sel;

    sha256_block_ctrl u_dut (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .START           (st1),
        .FIRST_BLOCK     (first),
        .LAST_BLOCK      (last),
        .MSG_VALID       (msg),
        .ABORT           (ab1),
        .SET_HASH        (sh1),
        .LOAD_EN         (le1),
        .LOAD_IDX        (li1),
        .SET_COMPRESSION (sc1),
        .COMPRESSION_EN  (ce1),
        .ROUND_IDX       (ri1),
        .LD_HASH         (lh1),
        .BUSY            (by1),
        .BLOCK_DONE      (bd1),
        .DONE            (dn1),
        .BLOCK_CNT       (bc1)
    );

    sha256_block_ctrl #(
        .ROUNDS     (80),
        .LOAD_WORDS (64),
        .SUM_CYCLES (4),
        .BLK_W      (16)
    ) u_dut2 (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .START           (st2),
        .FIRST_BLOCK     (first),
        .LAST_BLOCK      (last),
        .MSG_VALID       (msg),
        .ABORT           (ab2),
        .SET_HASH        (sh2),
        .LOAD_EN         (le2),
        .LOAD_IDX        (li2),
        .SET_COMPRESSION (sc2),
        .COMPRESSION_EN  (ce2),
        .ROUND_IDX       (ri2),
        .LD_HASH         (lh2),
        .BUSY            (by2),
        .BLOCK_DONE      (bd2),
        .DONE            (dn2),
        .BLOCK_CNT       (bc2)
    );

    logic       o_sh, o_le, o_ce, o_lh, o_by, o_bd, o_dn;
    logic [7:0] o_li, o_ri;
    logic [15:0] o_bc;
    assign o_sh = sel ? sh2 : sh1;
    assign o_le = sel ? le2 : le1;
    assign o_ce = sel ? ce2 : ce1;
    assign o_lh = sel ? lh2 : lh1;
    assign o_by = sel ? by2 : by1;
    assign o_bd = sel ? bd2 : bd1;
    assign o_dn = sel ? dn2 : dn1;
    assign o_li = sel ? 8'(li2) : 8'(li1);
    assign o_ri = sel ? 8'(ri2) : 8'(ri1);
    assign o_bc = sel ? bc2 : bc1;

    logic [35:0] all1;
    logic [37:0] all2;
    assign all1 = {sh1, le1, li1, sc1, ce1, ri1, lh1, by1, bd1, dn1, bc1};
    assign all2 = {sh2, le2, li2, sc2, ce2, ri2, lh2, by2, bd2, dn2, bc2};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        bit          first;
        bit          last;
        logic [31:0] gap;
        int          abort_rnd;
        int          busy_k;
        int          exp_lat;
        int          exp_sh;
        int          exp_ld;
        int          exp_cp;
        int          exp_lh;
        int          exp_done;
        int          exp_cnt;
    } vec_t;

    task automatic run_block(input int id, input vec_t v);
        int nload, ncomp, nsh, nlh, lat, idx_err, rnd_err;
        int f, abort_k, busy_ab;
        string p;
        nload = 0; ncomp = 0; nsh = 0; nlh = 0;
        idx_err = 0; rnd_err = 0;
        lat = -1; abort_k = -1; busy_ab = -1;
        f = v.first ? 1 : 0;
        p = $sformatf("v%0d", id);
        @(negedge clk);
        sel = v.sel;
        first = v.first;
        last = v.last;
        msg = 1'b1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            start = 1'b0;
            first = 1'b0;
            last = 1'b0;
            abort = 1'b0;
            msg = !(k >= f && k - f < 32 && v.gap[k-f]);
            if (k == v.busy_k) start = 1'b1;
            #1;
            if (abort_k >= 0 && k == abort_k + 1) busy_ab = int'(o_by);
            if (o_sh) nsh++;
            if (k >= f && nload < v.exp_ld && int'(o_li) != nload)
                idx_err++;
            if (o_le) nload++;
            if (o_ce) begin
                if (int'(o_ri) != ncomp) rnd_err++;
                ncomp++;
            end
            if (o_lh) nlh++;
            if (o_bd) begin
                lat = k;
                break;
            end
            if (v.abort_rnd >= 0 && o_ce && int'(o_ri) == v.abort_rnd) begin
                abort = 1'b1;
                abort_k = k;
            end
            if (abort_k >= 0 && k > abort_k + 20) break;
        end
        start = 1'b0;
        abort = 1'b0;
        chk({p, " latency"}, lat, v.exp_lat);
        chk({p, " set_hash"}, nsh, v.exp_sh);
        chk({p, " load_en"}, nload, v.exp_ld);
        chk({p, " load_idx"}, idx_err, 0);
        chk({p, " comp_en"}, ncomp, v.exp_cp);
        chk({p, " round_idx"}, rnd_err, 0);
        chk({p, " ld_hash"}, nlh, v.exp_lh);
        chk({p, " done"}, int'(o_dn), v.exp_done);
        chk({p, " block_cnt"}, int'(o_bc), v.exp_cnt);
        if (v.abort_rnd >= 0) chk({p, " busy_after_abort"}, busy_ab, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        //           sel f l gap          abt bsy lat sh ld cp lh dn cnt
        tv[0] = '{0, 1, 1, 32'h0,       -1, -1,  83, 1, 16, 64, 1, 1, 1};
        tv[1] = '{0, 1, 0, 32'h0,       -1, -1,  83, 1, 16, 64, 1, 0, 1};
        tv[2] = '{0, 0, 0, 32'h0,       -1, -1,  82, 0, 16, 64, 1, 0, 2};
        tv[3] = '{0, 0, 1, 32'h0,       -1, -1,  82, 0, 16, 64, 1, 1, 3};
        tv[4] = '{0, 1, 1, 32'h41089,   -1, -1,  88, 1, 16, 64, 1, 1, 1};
        tv[5] = '{0, 0, 1, 32'h224,     -1, -1,  85, 0, 16, 64, 1, 1, 2};
        tv[6] = '{0, 0, 1, 32'h0,       30, -1,  -1, 0, 16, 31, 0, 0, 2};
        tv[7] = '{0, 1, 1, 32'h0,       -1, -1,  83, 1, 16, 64, 1, 1, 1};
        tv[8] = '{0, 1, 0, 32'h0,       -1, 40,  83, 1, 16, 64, 1, 0, 1};
        tv[9] = '{1, 1, 1, 32'h0,       -1, -1, 150, 1, 64, 80, 1, 1, 1};

        #1;
        chk("reset_outputs_dut", $countones(all1), 0);
        chk("reset_outputs_dut2", $countones(all2), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_block(i, tv[i]);
        end

        @(posedge clk);
        #2;
        chk("block_done_pulse", int'(o_bd), 0);
        chk("idle_after_block", int'(o_by), 0);
        chk("done_level_holds", int'(o_dn), 1);

        @(negedge clk);
        sel = 1'b0;
        first = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = 1'b0;
        abort = 1'b0;
        #1;
        chk("start_abort_idle_busy", int'(o_by), 0);
        chk("start_abort_idle_sethash", int'(o_sh), 0);
        @(posedge clk);
        #2;
        chk("start_abort_idle_later", int'(o_by), 0);

        @(negedge clk);
        first = 1'b1;
        last = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = 1'b0;
        last = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("mid_compress_comp_en", int'(o_ce), 1);
        chk("mid_compress_round", int'(o_ri), 22);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", $countones(all1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("idle_after_reset", int'(o_by), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_block_ctrl.md
# sha256_block_ctrl

Parametrised block-sequencing controller for the SHA-256 hashing accelerator. It replaces the single-shot round controller with one that owns its own load and round counters and supports multi-block messages with hash chaining. It also handles stalling on message-word availability, configurable load, round and sum lengths, abort, and a START/BUSY/DONE handshake. It sits between the host interface and the datapath: message-schedule registers, working-variable compression registers and hash registers.

## Interface
- ROUNDS, 64: compression rounds per block; must be ≥ 2.
- LOAD_WORDS, 16: message words loaded per block; must be ≥ 1.
- SUM_CYCLES, 1: cycles spent in hash-sum; must be ≥ 1.
- BLK_W, 16: width of the block counter.
- IDX_W, $clog2(max(ROUNDS, LOAD_WORDS)): derived, not overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request to process one block; sampled only in IDLE.
- FIRST_BLOCK  in  1  qualifies START: reinitialise the hash to the IV before this block.
- LAST_BLOCK  in  1  qualifies START: raise DONE after this block.
- MSG_VALID  in  1  current message word present; load stalls while low.
- ABORT  in  1  synchronous abort of the in-flight block.
- SET_HASH  out  1  load the IV into the hash registers.
- LOAD_EN  out  1  write the message word at LOAD_IDX.
- LOAD_IDX  out  IDX_W  message word index.
- SET_COMPRESSION  out  1  copy hash registers into working variables.
- COMPRESSION_EN  out  1  advance one round.
- ROUND_IDX  out  IDX_W  current round, used for K/W select.
- LD_HASH  out  1  add working variables into the hash registers.
- BUSY  out  1  state ≠ IDLE.
- BLOCK_DONE  out  1  one-cycle pulse per completed block.
- DONE  out  1  level: final block of the message complete.
- BLOCK_CNT  out  BLK_W  blocks completed since the last FIRST_BLOCK start.

## Operation
- FSM states: IDLE, HASH_INIT, LOAD, COMP_SET, COMPRESS, HASH_SUM.
- Reset:
  - State → IDLE.
  - Counters, BLOCK_CNT, DONE and BLOCK_DONE → 0.
  - All outputs 0.
- IDLE:
  - START && FIRST_BLOCK → HASH_INIT.
  - START && !FIRST_BLOCK → LOAD, reusing the chained hash.
  - The LAST_BLOCK value captured with START is held internally until the block ends.
- HASH_INIT (1 cycle):
  - SET_HASH = 1.
  - BLOCK_CNT cleared.
  - → LOAD.
- LOAD:
  - LOAD_EN = MSG_VALID.
  - LOAD_IDX = count of accepted words.
  - When a word is accepted at LOAD_IDX = LOAD_WORDS−1 → COMP_SET.
  - MSG_VALID low: hold state and index.
- COMP_SET (1 cycle): SET_COMPRESSION = 1 → COMPRESS.
- COMPRESS:
  - COMPRESSION_EN = 1 for exactly ROUNDS cycles.
  - ROUND_IDX runs 0..ROUNDS−1.
  - At ROUNDS−1 → HASH_SUM.
- HASH_SUM:
  - SUM_CYCLES cycles; LD_HASH = 1 on the first cycle only.
  - On the final cycle → IDLE, BLOCK_CNT += 1 (wraps modulo 2^BLK_W), BLOCK_DONE pulses next cycle.
  - DONE is set if the captured LAST_BLOCK was 1.
- DONE:
  - Holds until the next accepted START, which clears it in the same edge that leaves IDLE.
- ABORT in any state other than IDLE:
  - → IDLE on the next edge; counters cleared.
  - No LD_HASH, BLOCK_DONE or DONE; BLOCK_CNT unchanged.
  - The hash registers are left undefined for chaining. The host must restart with FIRST_BLOCK.
- Simultaneous-event rules:
  - ABORT together with START in IDLE: START ignored.
  - START while BUSY: ignored.
  - ABORT on the HASH_SUM final cycle: abort wins.
- Outputs:
  - All control outputs are Moore-decoded from state and counters.
  - LOAD_EN is the only output combinational in an input (MSG_VALID).
  - BLOCK_DONE and DONE are registered.

## Timing
- START sampled at edge e0. With MSG_VALID held high, BLOCK_DONE is high in the cycle after edge e0 + F + LOAD_WORDS + 1 + ROUNDS + SUM_CYCLES (F = 1 if FIRST_BLOCK, else 0).
  - Defaults: 83 cycles for a first block, 82 for a chained block.
- Each low cycle of MSG_VALID during LOAD adds exactly one cycle.
- Back-to-back blocks: START may be asserted in the same cycle BLOCK_DONE is high. The block is accepted at that edge, giving 1 IDLE cycle between blocks.
- Reset mid-operation: outputs fall to 0 asynchronously. Operation resumes in IDLE after RESET_N deasserts, which is synchronised externally.

## Structure
- Package sha256_ctrl_pkg:
  - state enum typedef sha_ctrl_state_t.
  - default parameter constants SHA_ROUNDS = 64, SHA_LOAD_WORDS = 16.
- One sub-module, sha256_step_counter, instantiated twice (load index, round index):
  - ports: clear, enable, terminal-count parameter, wrap flag, count output.
- FSM and output decode live in sha256_block_ctrl.

## Test plan
- Single block, FIRST = LAST = 1, MSG_VALID constant:
  - SET_HASH for 1 cycle.
  - 16 LOAD_EN cycles, IDX 0..15.
  - 64 COMPRESSION_EN cycles, ROUND_IDX 0..63.
  - LD_HASH once.
  - BLOCK_DONE at cycle 83; DONE = 1; BLOCK_CNT = 1.
- Three chained blocks (FIRST only on block 0, LAST only on block 2):
  - SET_HASH exactly once.
  - BLOCK_DONE ×3; DONE only after the third; BLOCK_CNT = 3.
- MSG_VALID low on 5 scattered LOAD cycles:
  - LOAD_IDX holds during each gap.
  - BLOCK_DONE at cycle 88.
- ABORT asserted at ROUND_IDX = 30:
  - IDLE next cycle; no LD_HASH, BLOCK_DONE or DONE.
  - A subsequent START completes normally.
- Corner cases:
  - START while BUSY: ignored.
  - START + ABORT in IDLE: stays IDLE.
  - RESET_N low mid-COMPRESS: all outputs 0 immediately.
- Parameter sweep: ROUNDS = 80, LOAD_WORDS = 64, SUM_CYCLES = 4, single first block.
  - LD_HASH on exactly 1 of 4 sum cycles.
  - BLOCK_DONE at cycle 1+64+1+80+4 = 150.
